// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
//
// Quadrature encoder decoder with input synchronization, a run-length
// deglitch filter and a two-state tracking FSM.
//
// Parameters
//   WIDTH       position counter width (2..16)
//   FILTER_LEN  consecutive stable samples required before a new A/B value
//               is accepted (1..15)
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   quad_a   asynchronous encoder phase A
//   quad_b   asynchronous encoder phase B
//   enable   count enable; 0 holds count/dir but still tracks phase
//   clear    synchronous count clear (wins over a simultaneous step)
//   clr_err  clears the sticky error flag
//   count    position, wraps modulo 2^WIDTH
//   dir      direction of last counted step (1 = up, 0 = down)
//   step     one-cycle pulse per counted step
//   err      sticky illegal-transition flag
// ---------------------------------------------------------------------------
module quad_decoder #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             enable,
  input  logic             clear,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam logic [3:0] FILT_LEN = 4'(FILTER_LEN);

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronizers, one lane per phase. Bit 1 = A, bit 0 = B.
  // -------------------------------------------------------------------------
  logic [1:0] pins;
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;

  assign pins = {quad_a, quad_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= pins[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  // The synchronizer output still carries reset zeros for two cycles after
  // reset release; those are not real pin samples and must not be filtered
  // (with FILTER_LEN=1 they would otherwise be loaded as the start state).
  logic [1:0] fill_reg;
  logic       sample_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_reg <= 2'b00;
    end else begin
      fill_reg <= {fill_reg[0], 1'b1};
    end
  end

  assign sample_valid = fill_reg[1];

  // -------------------------------------------------------------------------
  // Run-length filter: cand_reg holds the most recent sample, run_reg how
  // many consecutive samples it has matched (saturating). A value is
  // "filtered" on the edge where its run reaches FILTER_LEN.
  // -------------------------------------------------------------------------
  logic [1:0] cand_reg;
  logic [1:0] cand_next;
  logic [3:0] run_reg;
  logic [3:0] run_next;
  logic       filtered;

  always_comb begin
    cand_next = cand_reg;
    run_next  = run_reg;
    if (sample_valid) begin
      if (sync2_reg != cand_reg) begin
        cand_next = sync2_reg;
        run_next  = 4'd1;
      end else if (run_reg != 4'hF) begin
        run_next = run_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_reg <= 2'b00;
      run_reg  <= 4'd0;
    end else begin
      cand_reg <= cand_next;
      run_reg  <= run_next;
    end
  end

  assign filtered = sample_valid && (run_next >= FILT_LEN);

  // -------------------------------------------------------------------------
  // Transition classification. Mapping AB to a position along the forward
  // Gray sequence 00->01->11->10 gives pos = {A, A^B}; the modulo-4
  // difference between new and accepted position is then 1 (up),
  // 3 (down) or 2 (both bits changed, illegal).
  // -------------------------------------------------------------------------
  logic [1:0] acc_reg;
  logic [1:0] pos_new;
  logic [1:0] pos_old;
  logic [1:0] pos_delta;

  assign pos_new   = {sync2_reg[1], sync2_reg[1] ^ sync2_reg[0]};
  assign pos_old   = {acc_reg[1],   acc_reg[1]   ^ acc_reg[0]};
  assign pos_delta = pos_new - pos_old;

  // -------------------------------------------------------------------------
  // FSM: state register / next-state logic / output decode
  // -------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (filtered) state_next = TRACK;
      TRACK:   state_next = TRACK;
      default: state_next = INIT;
    endcase
  end

  logic load_acc;
  logic move_up;
  logic move_down;
  logic illegal;

  always_comb begin
    load_acc  = 1'b0;
    move_up   = 1'b0;
    move_down = 1'b0;
    illegal   = 1'b0;
    case (state_reg)
      INIT: begin
        // First stable value is simply adopted as the reference.
        load_acc = filtered;
      end
      TRACK: begin
        if (filtered && (sync2_reg != acc_reg)) begin
          load_acc = 1'b1;
          case (pos_delta)
            2'd1:    move_up   = 1'b1;
            2'd3:    move_down = 1'b1;
            default: illegal   = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic counted;

  assign counted = enable && (move_up || move_down);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= 2'b00;
    end else if (load_acc) begin
      acc_reg <= sync2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= counted;

      // clear wins over the count update, but dir/step still report the step
      if (clear) begin
        count <= '0;
      end else if (enable && move_up) begin
        count <= count + 1'b1;
      end else if (enable && move_down) begin
        count <= count - 1'b1;
      end

      if (enable && move_up) begin
        dir <= 1'b1;
      end else if (enable && move_down) begin
        dir <= 1'b0;
      end

      // A new illegal transition beats a simultaneous clr_err.
      if (illegal) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
//
// Self-checking bench for quad_decoder (default parameters). A reference
// model tracks the decoder at the level of "settled pin values": each new
// stable AB value is classified by its step along the forward sequence
// 00,01,11,10 using a position table and modulo-4 arithmetic.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         quad_a;
  logic         quad_b;
  logic         enable;
  logic         clear;
  logic         clr_err;
  logic [W-1:0] count;
  logic         dir;
  logic         step;
  logic         err;

  quad_decoder #(.WIDTH(W), .FILTER_LEN(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .quad_a  (quad_a),
    .quad_b  (quad_b),
    .enable  (enable),
    .clear   (clear),
    .clr_err (clr_err),
    .count   (count),
    .dir     (dir),
    .step    (step),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // step pulse monitor
  int   step_total   = 0;
  int   double_steps = 0;
  logic prev_step    = 1'b0;

  always @(posedge clk) begin
    if (step === 1'b1) step_total++;
    if (step === 1'b1 && prev_step === 1'b1) double_steps++;
    prev_step = step;
  end

  // reference model state
  int         m_count = 0;
  logic       m_dir   = 1'b0;
  logic       m_err   = 1'b0;
  logic [1:0] m_acc   = 2'b00;
  int         m_steps = 0;
  int         pos_tbl[4];
  logic [W-1:0] exp_count;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model reaction to a newly accepted AB value.
  task automatic model_accept(input logic [1:0] nv);
    int delta;
    delta = (pos_tbl[nv] - pos_tbl[m_acc] + 4) % 4;
    if (delta == 1 && enable) begin
      m_count = (m_count + 1) % MOD;
      m_dir   = 1'b1;
      m_steps++;
    end else if (delta == 3 && enable) begin
      m_count = (m_count + MOD - 1) % MOD;
      m_dir   = 1'b0;
      m_steps++;
    end else if (delta == 2) begin
      m_err = 1'b1;
    end
    m_acc = nv;
  endtask

  task automatic move(input logic [1:0] nv, input int hold);
    {quad_a, quad_b} = nv;
    if (nv != m_acc) model_accept(nv);
    tick(hold);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    m_count = 0;
  endtask

  task automatic pulse_clr_err();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clear = 1'b0; clr_err = 1'b0;
    quad_a = 1'($urandom_range(0, 1)); quad_b = 1'($urandom_range(0, 1));
    tick(3);
    checks++;
    if ({count, dir, step, err} !== {8'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state count=%0d dir=%b step=%b err=%b required 0 0 0 0", count, dir, step, err);
    end
    {quad_a, quad_b} = 2'b11;
    tick(1);
    reset = 1'b0;
    tick(10);
    m_count = 0; m_dir = 1'b0; m_err = 1'b0; m_acc = 2'b11;
    checks++;
    if ({count, step, err} !== {8'd0, 2'b00}) begin
      errors++;
      $display("FAIL init_load count=%0d step=%b err=%b required 0 0 0", count, step, err);
    end
    $display("test_reset done count=%0d", count);
  endtask

  task automatic test_forward();
    int s0;
    s0 = step_total;
    move(2'b10, 8);
    move(2'b00, 8);
    move(2'b01, 8);
    checks++;
    if (count !== 8'd3 || dir !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL forward count=%0d dir=%b err=%b required 3 1 0", count, dir, err);
    end
    checks++;
    if (step_total - s0 !== 3) begin
      errors++;
      $display("FAIL forward_steps got %0d required 3", step_total - s0);
    end
    $display("test_forward count=%0d dir=%b steps=%0d", count, dir, step_total - s0);
  endtask

  task automatic test_wrap();
    pulse_clear();
    move(2'b00, 8);
    move(2'b10, 8);
    checks++;
    if (count !== 8'(MOD - 2) || dir !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down count=%0d dir=%b required %0d 0", count, dir, MOD - 2);
    end
    move(2'b00, 8);
    move(2'b01, 8);
    checks++;
    if (count !== 8'd0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up count=%0d dir=%b required 0 1", count, dir);
    end
    $display("test_wrap count=%0d dir=%b", count, dir);
  endtask

  task automatic test_glitch();
    int s0;
    move(2'b00, 8);
    exp_count = 8'(m_count);
    s0 = step_total;
    {quad_a, quad_b} = 2'b10;
    tick(2);
    {quad_a, quad_b} = 2'b00;
    tick(8);
    checks++;
    if (count !== exp_count || step_total !== s0) begin
      errors++;
      $display("FAIL glitch_short count=%0d steps=%0d required %0d 0", count, step_total - s0, exp_count);
    end
    move(2'b10, 5);
    exp_count = 8'(m_count);
    checks++;
    if (count !== exp_count) begin
      errors++;
      $display("FAIL glitch_long_mid count=%0d required %0d", count, exp_count);
    end
    move(2'b00, 8);
    exp_count = 8'(m_count);
    checks++;
    if (count !== exp_count || step_total - s0 !== 2) begin
      errors++;
      $display("FAIL glitch_long count=%0d steps=%0d required %0d 2", count, step_total - s0, exp_count);
    end
    $display("test_glitch count=%0d steps=%0d", count, step_total - s0);
  endtask

  task automatic test_error();
    exp_count = 8'(m_count);
    move(2'b11, 8);
    checks++;
    if (err !== 1'b1 || count !== exp_count) begin
      errors++;
      $display("FAIL illegal_jump err=%b count=%0d required 1 %0d", err, count, exp_count);
    end
    pulse_clr_err();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL clr_err err=%b required 0", err);
    end
    // second jump: clr_err coincides with the accept edge (E+4)
    {quad_a, quad_b} = 2'b00;
    model_accept(2'b00);
    tick(4);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (err !== 1'b1 || count !== exp_count) begin
      errors++;
      $display("FAIL clr_err_collide err=%b count=%0d required 1 %0d", err, count, exp_count);
    end
    tick(4);
    $display("test_error err=%b count=%0d", err, count);
  endtask

  task automatic test_latency();
    int early;
    early = 0;
    {quad_a, quad_b} = 2'b01;  // forward from 00, captured at the next edge E
    for (int i = 0; i < 4; i++) begin
      tick(1);                 // after E+i
      if (step !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL latency_early step high %0d times before E+4 required 0", early);
    end
    clear = 1'b1;
    tick(1);                   // after E+4
    clear = 1'b0;
    model_accept(2'b01);
    m_count = 0;
    checks++;
    if (step !== 1'b1 || dir !== 1'b1 || count !== 8'd0) begin
      errors++;
      $display("FAIL latency_clear step=%b dir=%b count=%0d required 1 1 0", step, dir, count);
    end
    tick(1);
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL step_width step=%b required 0", step);
    end
    tick(4);
    $display("test_latency count=%0d dir=%b", count, dir);
  endtask

  task automatic test_enable();
    int s0;
    pulse_clr_err();
    pulse_clear();
    move(2'b00, 8);
    move(2'b01, 8);
    exp_count = 8'(m_count);
    s0 = step_total;
    enable = 1'b0;
    move(2'b11, 8);
    move(2'b10, 8);
    move(2'b00, 8);
    checks++;
    if (count !== exp_count || step_total !== s0) begin
      errors++;
      $display("FAIL enable_hold count=%0d steps=%0d required %0d 0", count, step_total - s0, exp_count);
    end
    enable = 1'b1;
    move(2'b01, 8);
    checks++;
    if (count !== exp_count + 8'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL enable_resume count=%0d err=%b required %0d 0", count, err, exp_count + 8'd1);
    end
    $display("test_enable count=%0d", count);
  endtask

  task automatic test_mid_reset();
    int s0;
    logic [1:0] nv;
    move(2'b10, 8);            // ensure count is nonzero-ish
    nv = 2'b00;                // forward neighbour of 10
    s0 = step_total;
    {quad_a, quad_b} = nv;
    tick(2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    m_count = 0; m_dir = 1'b0; m_err = 1'b0; m_acc = nv;
    checks++;
    if (count !== 8'd0 || dir !== 1'b0 || err !== 1'b0 || step_total !== s0) begin
      errors++;
      $display("FAIL mid_reset count=%0d dir=%b err=%b steps=%0d required 0 0 0 0", count, dir, err, step_total - s0);
    end
    move(2'b01, 8);
    checks++;
    if (count !== 8'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_reload count=%0d dir=%b required 1 1", count, dir);
    end
    $display("test_mid_reset count=%0d", count);
  endtask

  task automatic test_random();
    logic [1:0] nv;
    int         r;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 1)      nv = m_acc ^ 2'b11;
      else if (r < 5) nv = 2'(pos_tbl[(pos_tbl[m_acc] + 1) % 4]);
      else            nv = 2'(pos_tbl[(pos_tbl[m_acc] + 3) % 4]);
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        quad_a = 1'($urandom_range(0, 1));
        quad_b = 1'($urandom_range(0, 1));
        tick($urandom_range(1, 2));
      end
      move(nv, $urandom_range(6, 10));
      exp_count = 8'(m_count);
      checks++;
      if (count !== exp_count || dir !== m_dir || err !== m_err) begin
        errors++;
        $display("FAIL random_%0d count=%0d dir=%b err=%b required %0d %b %b",
                 it, count, dir, err, exp_count, m_dir, m_err);
      end else begin
        $display("random_%0d ab=%b en=%b count=%0d dir=%b err=%b", it, nv, enable, count, dir, err);
      end
      if (m_err && $urandom_range(0, 1) == 1) pulse_clr_err();
    end
    enable = 1'b1;
  endtask

  task automatic test_step_totals();
    checks++;
    if (step_total !== m_steps) begin
      errors++;
      $display("FAIL step_total got %0d required %0d", step_total, m_steps);
    end
    checks++;
    if (double_steps !== 0) begin
      errors++;
      $display("FAIL step_back_to_back got %0d required 0", double_steps);
    end
  endtask

  initial begin
    // positions along the forward sequence, indexed by AB (also its inverse)
    pos_tbl[0] = 0;  // 00
    pos_tbl[1] = 1;  // 01
    pos_tbl[3] = 2;  // 11
    pos_tbl[2] = 3;  // 10
    test_reset();
    test_forward();
    test_wrap();
    test_glitch();
    test_error();
    test_latency();
    test_enable();
    test_mid_reset();
    test_random();
    test_step_totals();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
